// File: rtl/cpu_pkg.sv
// Shared definitions for the word serializer slice.
package cpu_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Serializer control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } ser_state_e;

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register with a full flag, for the word waiting behind the active one.
module word_hold_reg
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_take,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full
);

   logic [WIDTH-1:0] r_data;
   logic             r_full;

   // Capture on load, release on take; the parent never asserts both in one cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (i_load) begin
         r_data <= i_data;
         r_full <= 1'b1;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_full = r_full;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial word converter with one pending word, pause stall and registered outputs.
// Each rising edge "issues" at most one bit into the output registers. When the final bit of a
// word is issued, the pending word moves into the shift register on that same edge, so the
// holding slot is free (in_ready high) during the word_done cycle. Starting from IDLE with an
// empty holding slot, an accepted word flows straight into the shift register and its first
// bit is issued on the acceptance edge.
module word_serializer
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pause,
   output logic             shift_en,
   output logic             shift_bit,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   ser_state_e       r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
   logic             r_in_ready, r_shift_en, r_shift_bit, r_word_done, r_busy;

   logic             w_accept, w_active, w_start, w_run, w_last;
   logic             w_issue, w_bit;
   logic [WIDTH-1:0] w_src;
   logic             w_hold_load, w_hold_take, w_hold_full, w_full_nxt;
   logic [WIDTH-1:0] w_hold_data;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   word_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_hold_load),
      .i_take (w_hold_take),
      .i_data (in_data),
      .o_data (w_hold_data),
      .o_full (w_hold_full)
   );

   // Next-state, datapath and holding-slot control
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sreg_nxt  = r_sreg;
      w_issue     = 1'b0;
      w_bit       = 1'b0;
      w_hold_take = 1'b0;

      w_accept = in_valid & r_in_ready;
      w_active = (r_state != IDLE);
      w_start  = ~w_active & ~pause & (w_hold_full | w_accept);
      w_src    = w_hold_full ? w_hold_data : in_data;
      w_run    = w_active & ~pause;
      w_last   = w_run & (r_cnt == LAST);

      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = SHIFT;
               w_issue     = 1'b1;
               w_bit       = first_bit(w_src);
               w_sreg_nxt  = advance(w_src);
               w_cnt_nxt   = CW'(1);
               w_hold_take = w_hold_full;
            end
         end
         SHIFT, HOLD: begin
            if (pause) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = SHIFT;
               w_issue     = 1'b1;
               w_bit       = first_bit(r_sreg);
               w_sreg_nxt  = advance(r_sreg);
               w_cnt_nxt   = r_cnt + CW'(1);
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_hold_full) begin
                     w_sreg_nxt  = w_hold_data;
                     w_hold_take = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // An idle start from an empty slot bypasses the holding register
      w_hold_load = w_accept & ~(w_start & ~w_hold_full);
      w_full_nxt  = (w_hold_full & ~w_hold_take) | w_hold_load;
   end

   // State, datapath and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_sreg      <= '0;
         r_in_ready  <= 1'b0;
         r_shift_en  <= 1'b0;
         r_shift_bit <= 1'b0;
         r_word_done <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sreg      <= w_sreg_nxt;
         r_in_ready  <= ~w_full_nxt;
         r_shift_en  <= w_issue;
         r_shift_bit <= w_issue & w_bit;
         r_word_done <= w_last;
         r_busy      <= (w_state_nxt != IDLE) | w_full_nxt | w_issue;
      end
   end

   assign in_ready  = r_in_ready;
   assign shift_en  = r_shift_en;
   assign shift_bit = r_shift_bit;
   assign word_done = r_word_done;
   assign busy      = r_busy;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an MSB-first and an LSB-first instance share all inputs.
module tb_word_serializer;

   localparam int unsigned W = 32;

   logic          clock, reset, in_valid, pause;
   logic [W-1:0]  in_data;
   logic          m_ready, m_en, m_bit, m_done, m_busy;
   logic          l_ready, l_en, l_bit, l_done, l_busy;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   wc;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [31:0] data;
      logic        pause;
      logic        e_ready;
      logic        e_en;
      logic        e_bit;
      logic        e_done;
      logic        e_busy;
   } vec_t;

   vec_t vecs [11];

   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(m_ready),
      .pause(pause), .shift_en(m_en), .shift_bit(m_bit), .word_done(m_done), .busy(m_busy)
   );

   word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
      .pause(pause), .shift_en(l_en), .shift_bit(l_bit), .word_done(l_done), .busy(l_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; pause = 1'b0; in_data = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("post-reset in_ready", 32'(m_ready), 32'd1);
      chk("post-reset busy", 32'(m_busy), 32'd0);
   endtask

   task automatic expect_idle(input string tag);
      chk($sformatf("%s idle en", tag), 32'(m_en | l_en), 32'd0);
      chk($sformatf("%s idle done", tag), 32'(m_done | l_done), 32'd0);
      chk($sformatf("%s idle bit", tag), 32'(m_bit | l_bit), 32'd0);
      chk($sformatf("%s idle busy", tag), 32'(m_busy | l_busy), 32'd0);
      chk($sformatf("%s idle ready", tag), 32'(m_ready & l_ready), 32'd1);
   endtask

   // Checks 32 consecutive output cycles of word w on both instances
   task automatic expect_word(input logic [31:0] w, input int drop_valid_after,
                              input logic pause_after, input string tag);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("%s en[%0d]", tag, i), 32'(m_en & l_en), 32'd1);
         chk($sformatf("%s msb bit[%0d]", tag, i), 32'(m_bit), 32'(w[31-i]));
         chk($sformatf("%s lsb bit[%0d]", tag, i), 32'(l_bit), 32'(w[i]));
         chk($sformatf("%s done[%0d]", tag, i), 32'(m_done), 32'(i == 31));
         chk($sformatf("%s lsb done[%0d]", tag, i), 32'(l_done), 32'(i == 31));
         if (i == 31) pause = pause_after;
         tick();
         if (i + 1 == drop_valid_after) in_valid = 1'b0;
      end
   endtask

   initial begin
      //          rst   valid data          pause  ready en   bit  done busy
      vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'hC0000005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 11; i++) begin
         reset    = vecs[i].rst;
         in_valid = vecs[i].valid;
         in_data  = vecs[i].data;
         pause    = vecs[i].pause;
         tick();
         chk($sformatf("vec%0d in_ready", i), 32'(m_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d shift_en", i), 32'(m_en), 32'(vecs[i].e_en));
         chk($sformatf("vec%0d shift_bit", i), 32'(m_bit), 32'(vecs[i].e_bit));
         chk($sformatf("vec%0d word_done", i), 32'(m_done), 32'(vecs[i].e_done));
         chk($sformatf("vec%0d busy", i), 32'(m_busy), 32'(vecs[i].e_busy));
      end

      // Single word 0x80000001
      do_reset();
      in_valid = 1'b1; in_data = 32'h80000001;
      tick();
      in_valid = 1'b0;
      expect_word(32'h80000001, 0, 1'b0, "A");
      expect_idle("A");

      // Back-to-back all-ones then all-zeros
      in_valid = 1'b1; in_data = 32'hFFFFFFFF;
      tick();
      in_data = 32'h00000000;
      expect_word(32'hFFFFFFFF, 1, 1'b0, "B0");
      expect_word(32'h00000000, 0, 1'b0, "B1");
      expect_idle("B");

      // Five-cycle pause after output bit 10
      wc = 32'hA5A5A5A5;
      in_valid = 1'b1; in_data = wc;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 37; c++) begin
         int   idx;
         logic exp_en;
         exp_en = !(c >= 11 && c <= 15);
         idx    = (c <= 10) ? c : c - 5;
         chk($sformatf("C en[%0d]", c), 32'(m_en), 32'(exp_en));
         if (exp_en) begin
            chk($sformatf("C msb bit[%0d]", c), 32'(m_bit), 32'(wc[31-idx]));
            chk($sformatf("C lsb bit[%0d]", c), 32'(l_bit), 32'(wc[idx]));
         end else begin
            chk($sformatf("C stalled bit[%0d]", c), 32'(m_bit), 32'd0);
            chk($sformatf("C stalled busy[%0d]", c), 32'(m_busy), 32'd1);
         end
         chk($sformatf("C done[%0d]", c), 32'(m_done), 32'(c == 36));
         pause = (c >= 10 && c <= 14);
         tick();
      end
      expect_idle("C");

      // Third word offered while both slots are full
      in_valid = 1'b1; in_data = 32'h0F0F0F0F;
      tick();
      chk("D ready c0", 32'(m_ready), 32'd1);
      in_data = 32'h33333333;
      tick();
      in_data = 32'h55555555;
      for (int c = 1; c < 32; c++) begin
         chk($sformatf("D ready[%0d]", c), 32'(m_ready), 32'(c == 31));
         chk($sformatf("D done[%0d]", c), 32'(m_done), 32'(c == 31));
         chk($sformatf("D en[%0d]", c), 32'(m_en), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      expect_word(32'h33333333, 0, 1'b0, "D2");
      expect_word(32'h55555555, 0, 1'b0, "D3");
      expect_idle("D");

      // Pause raised in the final-bit cycle stalls only the next word
      in_valid = 1'b1; in_data = 32'hC3C3C3C3;
      tick();
      in_data = 32'h3C3C3C3C;
      expect_word(32'hC3C3C3C3, 1, 1'b1, "G0");
      chk("G stall0 en", 32'(m_en), 32'd0);
      chk("G stall0 busy", 32'(m_busy), 32'd1);
      tick();
      chk("G stall1 en", 32'(m_en), 32'd0);
      pause = 1'b0;
      tick();
      expect_word(32'h3C3C3C3C, 0, 1'b0, "G1");
      expect_idle("G");

      // Reset after output bit 16 with a second word pending
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      tick();
      in_data = 32'h12345678;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("E en[%0d]", c), 32'(m_en), 32'd1);
         if (c == 16) reset = 1'b1;
         tick();
      end
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("E reset%0d ready", r), 32'(m_ready), 32'd0);
         chk($sformatf("E reset%0d en", r), 32'(m_en), 32'd0);
         chk($sformatf("E reset%0d bit", r), 32'(m_bit), 32'd0);
         chk($sformatf("E reset%0d done", r), 32'(m_done), 32'd0);
         chk($sformatf("E reset%0d busy", r), 32'(m_busy), 32'd0);
         tick();
      end
      reset = 1'b0;
      tick();
      chk("E release ready", 32'(m_ready), 32'd1);
      for (int c = 0; c < 40; c++) begin
         chk($sformatf("E quiet[%0d]", c), 32'(m_en | m_done | l_en | l_done | m_busy), 32'd0);
         tick();
      end

      // LSB-first instance on 0x00000001
      in_valid = 1'b1; in_data = 32'h00000001;
      tick();
      in_valid = 1'b0;
      chk("F lsb first bit", 32'(l_bit), 32'd1);
      expect_word(32'h00000001, 0, 1'b0, "F");
      expect_idle("F");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
